// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream writer for the instruction memory.
// Writes one byte per accepted beat at consecutive addresses and checksums completed words.
module imem_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-2:0] word_count,
  input  logic                  abort,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [7:0]            mem_wdata,
  output logic [31:0]           last_word,
  output logic [31:0]           checksum,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-2:0] ONE_WORD = (ADDR_WIDTH-1)'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-2:0] words_rem;
  logic [23:0]           bytes_q;
  logic [31:0]           word_full;
  logic                  hs, word_end, last_of_load, at_cap, start_ok;

  assign hs           = in_valid && in_ready;
  assign word_end     = hs && (byte_idx == 2'd3);
  assign last_of_load = word_end && (words_rem == ONE_WORD);
  assign at_cap       = hs && (addr == ADDR_MAX);
  assign start_ok     = start && (state != LOAD);
  assign word_full    = {in_data, bytes_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (word_count == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (abort || last_of_load || at_cap) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == LOAD) && !abort;
    busy     = (state == LOAD);
    done     = (state == DONE);
  end

  // Write port and word bookkeeping all trail the handshake by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_word <= '0;
      checksum  <= '0;
      error     <= 1'b0;
      addr      <= BASE;
      byte_idx  <= '0;
      words_rem <= '0;
      bytes_q   <= '0;
    end else begin
      mem_we <= hs;
      if (hs) begin
        mem_addr  <= 32'(addr);
        mem_wdata <= in_data;
      end
      if (start_ok) begin
        addr      <= BASE;
        byte_idx  <= '0;
        words_rem <= word_count;
        checksum  <= '0;
        last_word <= '0;
        error     <= 1'b0;
      end else if (state == LOAD) begin
        if (abort) begin
          error <= 1'b1;
        end else if (hs) begin
          // Saturate at the top byte so the address can never wrap to 0.
          if (addr != ADDR_MAX) addr <= addr + ADDR_WIDTH'(1);
          byte_idx <= byte_idx + 2'd1;
          if (word_end) begin
            last_word <= word_full;
            checksum  <= checksum + word_full;
            words_rem <= words_rem - ONE_WORD;
          end else begin
            bytes_q[{byte_idx, 3'b000} +: 8] <= in_data;
          end
          if (at_cap && !last_of_load) error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader.
// Two instances (base 0x000 and 0xFF8) share one directed stimulus and a behavioural model.
module tb_imem_loader;
  localparam int AW = 12;
  localparam int B0 = 0;
  localparam int B1 = 32'hFF8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [AW-2:0] word_count = '0;
  logic [7:0]    in_data = '0;

  logic        in_ready[2], mem_we[2], busy[2], done[2], error[2];
  logic [31:0] mem_addr[2], last_word[2], checksum[2];
  logic [7:0]  mem_wdata[2];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt[2];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(B0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .last_word(last_word[0]),
    .checksum(checksum[0]), .busy(busy[0]), .done(done[0]), .error(error[0]));

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(B1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .last_word(last_word[1]),
    .checksum(checksum[1]), .busy(busy[1]), .done(done[1]), .error(error[1]));

  // Model: phase 0=idle 1=loading 2=finished; n = bytes accepted in this load.
  int          base[2] = '{B0, B1};
  int          m_phase[2];
  int unsigned m_n[2], m_wc[2];
  logic [31:0] m_cur[2], m_last[2], m_sum[2], m_addr[2];
  logic [7:0]  m_data[2];
  bit          m_err[2], m_we[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_n[i] = 0; m_wc[i] = 0; m_cur[i] = 0; m_last[i] = 0;
      m_sum[i] = 0; m_err[i] = 0; m_we[i] = 0; m_addr[i] = 0; m_data[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int unsigned a;
    m_we[i] = 0;
    if (m_phase[i] == 1) begin
      if (abort) begin
        m_phase[i] = 2; m_err[i] = 1;
      end else if (in_valid) begin
        a = base[i] + m_n[i];
        m_we[i] = 1; m_addr[i] = a; m_data[i] = in_data;
        m_cur[i] = m_cur[i] | (32'(in_data) << (8 * (m_n[i] % 4)));
        m_n[i]++;
        if (m_n[i] % 4 == 0) begin
          m_last[i] = m_cur[i]; m_sum[i] = m_sum[i] + m_cur[i]; m_cur[i] = 0;
        end
        if (m_n[i] == 4 * m_wc[i]) m_phase[i] = 2;
        else if (a == (1 << AW) - 1) begin m_phase[i] = 2; m_err[i] = 1; end
      end
    end else if (start) begin
      m_wc[i] = word_count; m_n[i] = 0; m_cur[i] = 0; m_sum[i] = 0; m_last[i] = 0;
      m_err[i] = 0; m_phase[i] = (word_count == 0) ? 2 : 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  initial begin
    wr_cnt[0] = 0; wr_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dut%0d in_ready", i), 32'(in_ready[i]), 32'(m_phase[i] == 1 && !abort));
        chk($sformatf("dut%0d busy", i), 32'(busy[i]), 32'(m_phase[i] == 1));
        chk($sformatf("dut%0d done", i), 32'(done[i]), 32'(m_phase[i] == 2));
        chk($sformatf("dut%0d error", i), 32'(error[i]), 32'(m_err[i]));
        chk($sformatf("dut%0d mem_we", i), 32'(mem_we[i]), 32'(m_we[i]));
        if (m_we[i]) begin
          chk($sformatf("dut%0d mem_addr", i), mem_addr[i], m_addr[i]);
          chk($sformatf("dut%0d mem_wdata", i), 32'(mem_wdata[i]), 32'(m_data[i]));
        end
        chk($sformatf("dut%0d last_word", i), last_word[i], m_last[i]);
        chk($sformatf("dut%0d checksum", i), checksum[i], m_sum[i]);
        if (mem_we[i] === 1'b1) wr_cnt[i]++;
      end
    end
  end

  logic [7:0] img[10] = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h33, 8'h01, 8'h00, 8'h00, 8'hAA, 8'hBB};
  int w0, w1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int wc);
    word_count = wc[AW-2:0]; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic feed(input int nbytes, input bit gap);
    for (int k = 0; k < nbytes; k++) begin
      in_valid = 1'b1; in_data = img[k]; tick();
      if (gap) begin in_valid = 1'b0; in_data = 8'hEE; tick(); end
    end
    in_valid = 1'b0; in_data = 8'hEE;
  endtask

  initial begin
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk("reset done", 32'(done[i]), 0);
      chk("reset mem_addr", mem_addr[i], 0);
    end
    rst_n = 1'b1; tick();

    do_start(2); feed(8, 0); tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk("t1 last_word", last_word[i], 32'h00000133);
      chk("t1 checksum", checksum[i], 32'h00100146);
      chk("t1 done", 32'(done[i]), 1);
      chk("t1 error", 32'(error[i]), 0);
    end

    w0 = wr_cnt[0];
    do_start(2); feed(8, 1); tick(); tick();
    chk("t2 checksum", checksum[0], 32'h00100146);
    chk("t2 writes", 32'(wr_cnt[0] - w0), 8);

    do_start(0);
    chk("t3 done", 32'(done[0]), 1);
    chk("t3 checksum", checksum[0], 0);
    chk("t3 mem_we", 32'(mem_we[0]), 0);
    tick();

    w0 = wr_cnt[0]; w1 = wr_cnt[1];
    do_start(4); feed(10, 0); tick();
    chk("t4 cap error", 32'(error[1]), 1);
    chk("t4 cap checksum", checksum[1], 32'h00100146);
    chk("t4 cap writes", 32'(wr_cnt[1] - w1), 8);
    chk("t4 base0 busy", 32'(busy[0]), 1);
    chk("t4 base0 writes", 32'(wr_cnt[0] - w0), 10);
    abort = 1'b1; tick(); abort = 1'b0; tick();

    w0 = wr_cnt[0];
    do_start(2); feed(3, 0);
    start = 1'b1; word_count = '0; in_valid = 1'b1; in_data = img[3]; tick(); start = 1'b0;
    for (int k = 4; k < 6; k++) begin in_data = img[k]; tick(); end
    abort = 1'b1; in_data = img[6]; tick();
    abort = 1'b0; in_valid = 1'b0; tick(); tick();
    chk("t5 writes", 32'(wr_cnt[0] - w0), 6);
    chk("t5 checksum", checksum[0], 32'h00100013);
    chk("t5 error", 32'(error[0]), 1);
    chk("t5 done", 32'(done[0]), 1);

    do_start(2); feed(5, 0);
    #2 rst_n = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      chk("t6 rst mem_we", 32'(mem_we[i]), 0);
      chk("t6 rst mem_addr", mem_addr[i], 0);
      chk("t6 rst checksum", checksum[i], 0);
      chk("t6 rst busy", 32'(busy[i]), 0);
    end
    @(posedge clk); #1 rst_n = 1'b1; tick();
    w0 = wr_cnt[0];
    do_start(2); feed(8, 0); tick(); tick();
    chk("t6 fresh checksum", checksum[0], 32'h00100146);
    chk("t6 fresh writes", 32'(wr_cnt[0] - w0), 8);
    chk("t6 fresh done", 32'(done[1]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
